seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
Parametrised, run-time programmable input-sequence detector. It succeeds the hard-coded two-input sequence FSM.
- Width: IN_W-bit sample bus.
- Pattern: up to MAX_STEPS steps, each with a per-bit care mask.
- Timing: valid-qualified sampling and an idle timeout.
- Modes: selectable restart behaviour.
- Outputs: match pulse and saturating hit counter.
Sits between the input synchroniser and the control/status logic that consumes match events.

Parameters:
IN_W, 2, width of sampled input bus
MAX_STEPS, 16, pattern storage depth (steps)
IDX_W, 4, step index width, equals clog2(MAX_STEPS)
TO_W, 8, idle-timeout counter width
CNT_W, 16, match counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  detector enable; 0 = idle, config allowed
in_valid  in  1  in_data is a sample this cycle
in_data  in  IN_W  sample value
cfg_we  in  1  write pattern step
cfg_addr  in  IDX_W  step index to write
cfg_pat  in  IN_W  expected value for step
cfg_mask  in  IN_W  care bits for step (1 = compare)
cfg_len  in  IDX_W+1  number of active steps, 1..MAX_STEPS
cfg_restart  in  1  0 = mismatch returns to step 0; 1 = mismatching sample re-tested against step 0
cfg_timeout  in  TO_W  idle cycles before abandoning partial match; 0 = no timeout
cfg_err  out  1  one-cycle pulse: cfg_we while en=1 (write dropped)
match  out  1  one-cycle pulse: full sequence seen
timeout  out  1  one-cycle pulse: partial match abandoned by timeout
step  out  IDX_W  current step index (next step expected)
match_cnt  out  CNT_W  saturating count of match pulses

Behaviour:
- Reset, asynchronous, active-high: step=0, match=0, timeout=0, cfg_err=0, match_cnt=0, idle counter=0. Pattern/mask storage is cleared to pat=0, mask=0.
- Reset mid-sequence drops the partial match immediately. No match or timeout pulse is produced.
- Step k hits when ((in_data ^ pat[k]) & mask[k]) == 0. mask=0 is a wildcard step.
- Config writes: cfg_we with en=0 writes pat/mask[cfg_addr] at the clock edge. cfg_addr >= MAX_STEPS is ignored. cfg_we with en=1 is dropped, and cfg_err pulses the next cycle.
- cfg_len, cfg_restart and cfg_timeout are sampled live. Change them only while en=0.
- cfg_len=0 or cfg_len>MAX_STEPS: detector stays at step 0 and never matches.
- States: IDLE (en=0), TRACK (en=1). Deasserting en forces step←0 and clears the idle counter next edge. No pulses are generated.
- TRACK, in_valid=1, sample hits step s:
  - s==cfg_len-1: match=1 next cycle, step←0, match_cnt←match_cnt+1, saturating at all-ones.
  - otherwise: step←s+1.
- TRACK, in_valid=1, sample misses:
  - cfg_restart=0: step←0.
  - cfg_restart=1: step←1 if the sample hits step 0 (cfg_len>1), else step←0.
  - cfg_restart=1 and cfg_len==1: a hit on step 0 is a match.
- Latency: match, step and match_cnt update on the edge after the qualifying sample (1 cycle). Back-to-back matches on consecutive samples are supported.
- Idle timeout: counter clears on every in_valid and whenever step==0. It increments each cycle with in_valid=0 and step!=0. When it reaches cfg_timeout (cfg_timeout!=0): step←0, timeout pulses 1 cycle, counter clears.
- Simultaneous events: in_valid on the cycle the counter would expire takes priority. The sample is processed and there is no timeout.
- All pulse outputs are registered, glitch-free, and high for exactly one cycle.

Test Plan:
- Reset, then en=1 with no config -> cfg_len=0 path: random samples give match=0, step=0. Assert reset mid-run at step=3 -> all outputs 0 immediately, match_cnt=0.
- IN_W=2, cfg_len=11, steps (pat/mask) 01/01, 10/10, 00/01, 00/10, 01/01, 10/10, 00/01, 00/10, 10/10, 01/01, 00/01, with in_valid each cycle -> step counts 1..10, match pulses once the cycle after the 11th sample, match_cnt=1.
- Same pattern, cfg_restart=0, wrong sample 2'b00 at step 5 -> step=0. With cfg_restart=1 and sample 2'b01 at step 5 (a step-0 hit) -> step=1.
- cfg_timeout=4, advance to step 3, then hold in_valid=0 -> timeout pulses after 4 idle cycles, step=0. Repeat with in_valid asserted on the 4th idle cycle -> no timeout, sample processed.
- cfg_len=1, pat=2'b11/mask=2'b11, 3 consecutive 2'b11 samples -> 3 back-to-back match pulses, match_cnt=3. Preload a test with CNT_W=2 -> counter saturates at 3.
- cfg_we during en=1 -> cfg_err pulses once and storage is unchanged (readback via subsequent matching). en dropped at step 6 -> step=0 next edge, no pulses.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Run-time programmable sequence detector: matches up to MAX_STEPS masked samples
// in order, with restart modes, an idle timeout and a saturating match counter.
module seq_pattern_detector #(
  parameter int IN_W      = 2,
  parameter int MAX_STEPS = 16,
  parameter int IDX_W     = 4,
  parameter int TO_W      = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [IN_W-1:0]  cfg_pat,
  input  logic [IN_W-1:0]  cfg_mask,
  input  logic [IDX_W:0]   cfg_len,
  input  logic             cfg_restart,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             cfg_err,
  output logic             match,
  output logic             timeout,
  output logic [IDX_W-1:0] step,
  output logic [CNT_W-1:0] match_cnt
);

  logic [IN_W-1:0]  pat_mem  [MAX_STEPS];
  logic [IN_W-1:0]  mask_mem [MAX_STEPS];
  logic [TO_W-1:0]  idle_cnt;
  logic [TO_W-1:0]  idle_next;
  logic [IDX_W:0]   last_idx;
  logic             len_ok;
  logic             addr_ok;
  logic             at_last;
  logic             hit_cur;
  logic             hit_first;
  logic             expire;

  assign len_ok    = (cfg_len != '0) && (int'(cfg_len) <= MAX_STEPS);
  assign addr_ok   = int'(cfg_addr) < MAX_STEPS;
  assign last_idx  = cfg_len - 1'b1;
  assign at_last   = ({1'b0, step} == last_idx);
  assign hit_cur   = ((in_data ^ pat_mem[step]) & mask_mem[step]) == '0;
  assign hit_first = ((in_data ^ pat_mem[0]) & mask_mem[0]) == '0;
  assign idle_next = idle_cnt + 1'b1;
  assign expire    = (cfg_timeout != '0) && (idle_next == cfg_timeout);

  // A valid sample always takes priority over an expiring idle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step      <= '0;
      idle_cnt  <= '0;
      match     <= 1'b0;
      timeout   <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
      for (int i = 0; i < MAX_STEPS; i++) begin
        pat_mem[i]  <= '0;
        mask_mem[i] <= '0;
      end
    end else begin
      match   <= 1'b0;
      timeout <= 1'b0;
      cfg_err <= cfg_we & en;

      if (cfg_we && !en && addr_ok) begin
        pat_mem[cfg_addr]  <= cfg_pat;
        mask_mem[cfg_addr] <= cfg_mask;
      end

      if (!en || !len_ok) begin
        step     <= '0;
        idle_cnt <= '0;
      end else if (in_valid) begin
        idle_cnt <= '0;
        if (hit_cur) begin
          if (at_last) begin
            match <= 1'b1;
            step  <= '0;
            if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end else if (cfg_restart && hit_first) begin
          // Reached only from step!=0, since at step 0 hit_cur == hit_first.
          step <= {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
          step <= '0;
        end
      end else if (step == '0) begin
        idle_cnt <= '0;
      end else if (expire) begin
        step     <= '0;
        idle_cnt <= '0;
        timeout  <= 1'b1;
      end else begin
        idle_cnt <= idle_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomised and directed bench for seq_pattern_detector, checked against a
// step-rule reference model; a second instance with CNT_W=2 covers saturation.
module tb_seq_pattern_detector;

  logic       clk, reset, en, in_valid, cfg_we, cfg_restart;
  logic [1:0] in_data, cfg_pat, cfg_mask;
  logic [3:0] cfg_addr;
  logic [4:0] cfg_len;
  logic [7:0] cfg_timeout;

  logic        cfg_err, match, timeout;
  logic [3:0]  step;
  logic [15:0] match_cnt;
  logic        cfg_err2, match2, timeout2;
  logic [3:0]  step2;
  logic [1:0]  match_cnt2;

  int compare_count = 0;
  int mismatch_count = 0;

  int m_pat [16];
  int m_mask[16];
  int m_step, m_idle, m_cnt, m_cnt2;
  bit exp_match, exp_timeout, exp_err;

  int seq_pat [11] = '{1, 2, 0, 0, 1, 2, 0, 0, 2, 1, 0};
  int seq_mask[11] = '{1, 2, 1, 2, 1, 2, 1, 2, 2, 1, 1};

  seq_pattern_detector dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cfg_len(cfg_len), .cfg_restart(cfg_restart), .cfg_timeout(cfg_timeout),
    .cfg_err(cfg_err), .match(match), .timeout(timeout), .step(step), .match_cnt(match_cnt)
  );

  seq_pattern_detector #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cfg_len(cfg_len), .cfg_restart(cfg_restart), .cfg_timeout(cfg_timeout),
    .cfg_err(cfg_err2), .match(match2), .timeout(timeout2), .step(step2), .match_cnt(match_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit m_hit(int k, int d);
    return ((d ^ m_pat[k]) & m_mask[k]) == 0;
  endfunction

  function automatic logic [1:0] hit_data(int k);
    logic [1:0] r;
    r = 2'($urandom);
    return (2'(m_pat[k]) & 2'(m_mask[k])) | (r & ~2'(m_mask[k]));
  endfunction

  // Next-state rules of the detector, applied to the inputs present before the edge.
  task automatic model_step();
    exp_match   = 0;
    exp_timeout = 0;
    exp_err     = cfg_we && en;
    if (!en || cfg_len == 0 || cfg_len > 16) begin
      m_step = 0;
      m_idle = 0;
    end else if (in_valid) begin
      m_idle = 0;
      if (m_hit(m_step, int'(in_data))) begin
        if (m_step == int'(cfg_len) - 1) begin
          exp_match = 1;
          m_step = 0;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end else begin
          m_step++;
        end
      end else if (cfg_restart && m_hit(0, int'(in_data))) begin
        m_step = 1;
      end else begin
        m_step = 0;
      end
    end else if (m_step != 0) begin
      m_idle++;
      if (cfg_timeout != 0 && m_idle == int'(cfg_timeout)) begin
        m_step = 0;
        m_idle = 0;
        exp_timeout = 1;
      end
    end else begin
      m_idle = 0;
    end
    if (cfg_we && !en) begin
      m_pat[cfg_addr]  = int'(cfg_pat);
      m_mask[cfg_addr] = int'(cfg_mask);
    end
  endtask

  task automatic check_all();
    checkOutput("step", 32'(step), m_step);
    checkOutput("match", 32'(match), 32'(exp_match));
    checkOutput("timeout", 32'(timeout), 32'(exp_timeout));
    checkOutput("cfg_err", 32'(cfg_err), 32'(exp_err));
    checkOutput("match_cnt", 32'(match_cnt), m_cnt);
    checkOutput("match_cnt_sat", 32'(match_cnt2), m_cnt2);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic applyStimulus(input logic v_en, input logic v_valid, input logic [1:0] v_data);
    en       = v_en;
    in_valid = v_valid;
    in_data  = v_data;
    cfg_we   = 1'b0;
    cycle();
  endtask

  task automatic write_step(input int addr, input int pat, input int mask);
    en       = 1'b0;
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_pat  = 2'(pat);
    cfg_mask = 2'(mask);
    cycle();
    cfg_we   = 1'b0;
  endtask

  task automatic advance_to(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b1, hit_data(k));
  endtask

  // Asynchronous reset between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_step = 0; m_idle = 0; m_cnt = 0; m_cnt2 = 0;
    for (int i = 0; i < 16; i++) begin
      m_pat[i] = 0;
      m_mask[i] = 0;
    end
    checkOutput("rst_step", 32'(step), 0);
    checkOutput("rst_match", 32'(match), 0);
    checkOutput("rst_timeout", 32'(timeout), 0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 0);
    checkOutput("rst_match_cnt", 32'(match_cnt), 0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_pat = '0; cfg_mask = '0; cfg_len = '0; cfg_restart = 1'b0;
    cfg_timeout = '0;
    @(posedge clk);
    #1;
    do_reset();

    $display("[TB] cfg_len=0 path");
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 2'($urandom));
    checkOutput("len0_step", 32'(step), 0);

    $display("[TB] eleven-step sequence");
    for (int k = 0; k < 11; k++) write_step(k, seq_pat[k], seq_mask[k]);
    cfg_len = 5'd11;
    applyStimulus(1'b0, 1'b0, 2'b00);
    advance_to(10);
    checkOutput("seq_step10", 32'(step), 10);
    applyStimulus(1'b1, 1'b1, hit_data(10));
    checkOutput("seq_match", 32'(match), 1);
    checkOutput("seq_cnt", 32'(match_cnt), 1);

    $display("[TB] restart modes");
    advance_to(5);
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkOutput("restart0_step", 32'(step), 0);
    applyStimulus(1'b0, 1'b0, 2'b00);
    cfg_restart = 1'b1;
    advance_to(5);
    applyStimulus(1'b1, 1'b1, 2'b01);
    checkOutput("restart1_step", 32'(step), 1);

    $display("[TB] idle timeout");
    applyStimulus(1'b0, 1'b0, 2'b00);
    cfg_timeout = 8'd4;
    advance_to(3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 2'b00);
    checkOutput("to_pulse", 32'(timeout), 1);
    checkOutput("to_step", 32'(step), 0);
    advance_to(3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b1, hit_data(3));
    checkOutput("to_priority_pulse", 32'(timeout), 0);
    checkOutput("to_priority_step", 32'(step), 4);

    $display("[TB] write while enabled, enable drop");
    applyStimulus(1'b0, 1'b0, 2'b00);
    cfg_timeout = 8'd0;
    en = 1'b1; in_valid = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_pat = 2'b10; cfg_mask = 2'b11;
    cycle();
    cfg_we = 1'b0;
    checkOutput("err_pulse", 32'(cfg_err), 1);
    applyStimulus(1'b1, 1'b1, 2'b01);
    checkOutput("err_no_write", 32'(step), 1);
    applyStimulus(1'b0, 1'b0, 2'b00);
    advance_to(6);
    applyStimulus(1'b0, 1'b1, hit_data(6));
    checkOutput("en_drop_step", 32'(step), 0);
    checkOutput("en_drop_match", 32'(match), 0);

    $display("[TB] single-step back-to-back matches");
    write_step(0, 3, 3);
    cfg_len = 5'd1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'b11);
    checkOutput("b2b_cnt", 32'(match_cnt), 5);
    checkOutput("b2b_sat", 32'(match_cnt2), 3);

    $display("[TB] reset mid-sequence");
    applyStimulus(1'b0, 1'b0, 2'b00);
    write_step(0, 1, 1);
    cfg_len = 5'd11;
    advance_to(3);
    do_reset();
    cfg_len = 5'd1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 2'($urandom));
    checkOutput("wildcard_cnt", 32'(match_cnt), 3);

    $display("[TB] randomised rounds");
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b0, 1'b0, 2'b00);
      for (int w = 0; w < 6; w++) write_step($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
      cfg_len     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 17)) : 5'($urandom_range(1, 6));
      cfg_restart = 1'($urandom);
      cfg_timeout = 8'($urandom_range(0, 5));
      for (int i = 0; i < 60; i++) begin
        en       = 1'b1;
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = ($urandom_range(0, 1) == 0) ? hit_data(m_step) : 2'($urandom);
        cfg_we   = ($urandom_range(0, 15) == 0);
        cfg_addr = 4'($urandom);
        cfg_pat  = 2'($urandom);
        cfg_mask = 2'($urandom);
        cycle();
        cfg_we   = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
